// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: SEW codes, op types,
// sequencer state encoding and the chunk-count helper.
package vec_pkg;

    localparam logic [2:0] E8  = 3'd0;
    localparam logic [2:0] E16 = 3'd1;
    localparam logic [2:0] E32 = 3'd2;
    localparam logic [2:0] E64 = 3'd3;

    localparam logic [1:0] OP_VV = 2'd0;
    localparam logic [1:0] OP_VX = 2'd1;
    localparam logic [1:0] OP_VI = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // Elements narrower than the lane still take one chunk each.
    function automatic logic [3:0] chunks_per_elem(input logic [2:0] vsew,
                                                   input int unsigned lane_width);
        int unsigned sewLog;
        sewLog = 32'(vsew) + 32'd3;
        if (sewLog > lane_width)
            return 4'(32'd1 << (sewLog - lane_width));
        else
            return 4'd1;
    endfunction

endpackage

// File: rtl/vec_lane_seq_if.sv
// Sequencer-to-ALU lane handshake: chunk request going out, chunk result coming back.
interface vec_lane_seq_if;
    logic        run;
    logic [9:0]  index;
    logic [3:0]  in_reg_offset;
    logic [63:0] vd_in;

    modport master (output run, output index, output in_reg_offset, input vd_in);
    modport slave  (input run, input index, input in_reg_offset, output vd_in);
endinterface

// File: rtl/vec_chunk_writer.sv
// Holds the VLEN-wide destination image and merges one 2^cw_log2-bit chunk
// per enabled cycle at an arbitrary bit offset.
module vec_chunk_writer #(
    parameter int unsigned VLEN = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear_i,
    input  logic            wr_en_i,
    input  logic [9:0]      bit_off_i,
    input  logic [2:0]      cw_log2_i,
    input  logic [63:0]     data_i,
    output logic [VLEN-1:0] image_o
);

    logic [VLEN-1:0] image_q, image_d;
    logic [63:0]     mask64;
    logic [6:0]      cwBits;
    logic [VLEN-1:0] wideMask, wideData;

    always_comb begin
        cwBits   = 7'd1 << cw_log2_i;
        mask64   = (cw_log2_i >= 3'd6) ? '1 : ((64'd1 << cwBits) - 64'd1);
        wideMask = VLEN'(mask64) << bit_off_i;
        wideData = VLEN'(data_i & mask64) << bit_off_i;
        image_d  = image_q;
        if (clear_i)
            image_d = '0;
        else if (wr_en_i)
            image_d = (image_q & ~wideMask) | wideData;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            image_q <= '0;
        else
            image_q <= image_d;
    end

    assign image_o = image_q;

endmodule

// File: rtl/vec_lane_seq.sv
// Per-lane chunk sequencer: walks the elements this lane owns, LSB chunk first,
// and assembles the combinational ALU results into a VLEN-wide image.
module vec_lane_seq
    import vec_pkg::*;
#(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned LANE_I     = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        vsew,
    input  logic [1:0]        nb_lanes,
    vec_lane_seq_if.master    alu,
    output logic [VLEN-1:0]   vd_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_e  state_q, state_d;
    logic [2:0]  vsew_q, vsew_d;
    logic [1:0]  nbl_q, nbl_d;
    logic [9:0]  elem_q, elem_d;
    logic [3:0]  off_q, off_d;
    logic        err_q, err_d;

    logic [3:0]  sewLog;
    logic [3:0]  nch;
    logic [31:0] nel;
    logic [9:0]  elemNext;
    logic        lastOff;
    logic        startIllegal;
    logic [31:0] startNel;
    logic [2:0]  cwLog2;
    logic        clearImage;

    assign sewLog   = 4'(vsew_q) + 4'd3;
    assign nch      = chunks_per_elem(vsew_q, LANE_WIDTH);
    assign nel      = VLEN >> sewLog;
    assign elemNext = elem_q + (10'd1 << nbl_q);
    assign lastOff  = (off_q == nch - 4'd1);
    assign cwLog2   = (32'(sewLog) > LANE_WIDTH) ? 3'(LANE_WIDTH) : 3'(sewLog);

    // Legality and ownership are judged on the live inputs at the accepting edge.
    assign startIllegal = (vsew > E64) || ((32'd8 << vsew) > VLEN);
    assign startNel     = VLEN >> (32'(vsew) + 32'd3);

    assign alu.index         = 10'((32'(elem_q) << sewLog) + (32'(off_q) << LANE_WIDTH));
    assign alu.in_reg_offset = off_q;
    assign err               = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SEQ_IDLE;
            vsew_q  <= '0;
            nbl_q   <= '0;
            elem_q  <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsew_q  <= vsew_d;
            nbl_q   <= nbl_d;
            elem_q  <= elem_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vsew_d     = vsew_q;
        nbl_d      = nbl_q;
        elem_d     = elem_q;
        off_d      = off_q;
        err_d      = err_q;
        clearImage = 1'b0;
        alu.run    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    vsew_d     = vsew;
                    nbl_d      = nb_lanes;
                    elem_d     = 10'(LANE_I);
                    off_d      = '0;
                    clearImage = 1'b1;
                    err_d      = startIllegal;
                    if (startIllegal || (LANE_I >= startNel))
                        state_d = SEQ_DONE;
                    else
                        state_d = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                alu.run = 1'b1;
                busy    = 1'b1;
                if (lastOff) begin
                    off_d  = '0;
                    elem_d = elemNext;
                    if (32'(elemNext) >= nel)
                        state_d = SEQ_DONE;
                end else begin
                    off_d = off_q + 4'd1;
                end
            end
            SEQ_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    vec_chunk_writer #(.VLEN(VLEN)) u_writer (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (clearImage),
        .wr_en_i   (alu.run),
        .bit_off_i (alu.index),
        .cw_log2_i (cwLog2),
        .data_i    (alu.vd_in),
        .image_o   (vd_out)
    );

endmodule

// File: tb/tb_vec_lane_seq.sv
// Directed bench for vec_lane_seq: three lane configurations driven by a vadd lane model.
module tb_vec_lane_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic [2:0]   vsew;
    logic [1:0]   nbLanes;
    logic         startS [3];
    logic [127:0] vdOut  [3];
    logic         busyS  [3];
    logic         doneS  [3];
    logic         errS   [3];
    logic         runS   [3];
    logic [9:0]   idxS   [3];
    logic [3:0]   offS   [3];
    logic [127:0] vs1, vs2;

    int checks = 0;
    int errors = 0;
    int idxQ[$];
    int offQ[$];

    vec_lane_seq_if ifA ();
    vec_lane_seq_if ifB ();
    vec_lane_seq_if ifC ();

    vec_lane_seq #(.VLEN(128), .LANE_WIDTH(4), .LANE_I(0)) dutA (
        .clk(clk), .resetn(resetn), .start(startS[0]), .vsew(vsew), .nb_lanes(nbLanes),
        .alu(ifA), .vd_out(vdOut[0]), .busy(busyS[0]), .done(doneS[0]), .err(errS[0]));
    vec_lane_seq #(.VLEN(128), .LANE_WIDTH(4), .LANE_I(1)) dutB (
        .clk(clk), .resetn(resetn), .start(startS[1]), .vsew(vsew), .nb_lanes(nbLanes),
        .alu(ifB), .vd_out(vdOut[1]), .busy(busyS[1]), .done(doneS[1]), .err(errS[1]));
    vec_lane_seq #(.VLEN(128), .LANE_WIDTH(3), .LANE_I(0)) dutC (
        .clk(clk), .resetn(resetn), .start(startS[2]), .vsew(vsew), .nb_lanes(nbLanes),
        .alu(ifC), .vd_out(vdOut[2]), .busy(busyS[2]), .done(doneS[2]), .err(errS[2]));

    // vadd lane model: lw-bit add of the chunk at idx, carry-in from the previous chunk.
    function automatic logic [64:0] aluAdd(input logic [127:0] a, input logic [127:0] b,
                                           input logic [9:0] idx, input int lw, input logic cin);
        logic [63:0]  m;
        logic [127:0] sa, sb;
        m  = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
        sa = a >> idx;
        sb = b >> idx;
        return {1'b0, sa[63:0] & m} + {1'b0, sb[63:0] & m} + 65'(cin);
    endfunction

    logic [64:0] sumA, sumB, sumC;
    logic        cqA, cqB, cqC;

    assign sumA = aluAdd(vs1, vs2, ifA.index, 16, (ifA.in_reg_offset != 0) ? cqA : 1'b0);
    assign sumB = aluAdd(vs1, vs2, ifB.index, 16, (ifB.in_reg_offset != 0) ? cqB : 1'b0);
    assign sumC = aluAdd(vs1, vs2, ifC.index, 8,  (ifC.in_reg_offset != 0) ? cqC : 1'b0);
    assign ifA.vd_in = ifA.run ? sumA[63:0] : 64'd0;
    assign ifB.vd_in = ifB.run ? sumB[63:0] : 64'd0;
    assign ifC.vd_in = ifC.run ? sumC[63:0] : 64'd0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cqA <= 1'b0; cqB <= 1'b0; cqC <= 1'b0;
        end else begin
            cqA <= ifA.run ? sumA[16] : 1'b0;
            cqB <= ifB.run ? sumB[16] : 1'b0;
            cqC <= ifC.run ? sumC[8]  : 1'b0;
        end
    end

    assign runS[0] = ifA.run;  assign idxS[0] = ifA.index;  assign offS[0] = ifA.in_reg_offset;
    assign runS[1] = ifB.run;  assign idxS[1] = ifB.index;  assign offS[1] = ifB.in_reg_offset;
    assign runS[2] = ifC.run;  assign idxS[2] = ifC.index;  assign offS[2] = ifC.in_reg_offset;

    // Reference image: element-wise sum mod 2^sew for the elements this lane owns.
    function automatic logic [127:0] expImage(input logic [127:0] a, input logic [127:0] b,
                                              input int sew, input int laneI, input int stride);
        logic [127:0] img, m, s;
        int nel;
        img = '0;
        nel = 128 / sew;
        m   = (sew == 64) ? {64'd0, {64{1'b1}}} : ((128'd1 << sew) - 128'd1);
        for (int e = laneI; e < nel; e += stride) begin
            s   = ((a >> (e * sew)) + (b >> (e * sew))) & m;
            img = img | (s << (e * sew));
        end
        return img;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Pulses start on one lane and follows it to done, logging every run cycle.
    task automatic applyStimulus(input int sel, input logic [2:0] sewCode, input logic [1:0] nb,
                                 input int restartAt, output int runCycles, output int doneAt);
        int cyc;
        idxQ.delete();
        offQ.delete();
        @(negedge clk);
        vsew        = sewCode;
        nbLanes     = nb;
        startS[sel] = 1'b1;
        @(negedge clk);
        startS[sel] = 1'b0;
        vsew        = 3'd7;
        nbLanes     = 2'd3;
        cyc         = 1;
        runCycles   = 0;
        doneAt      = 0;
        while (cyc < 200 && doneAt == 0) begin
            if (runS[sel]) begin
                runCycles++;
                idxQ.push_back(int'(idxS[sel]));
                offQ.push_back(int'(offS[sel]));
            end
            if (doneS[sel])
                doneAt = cyc;
            startS[sel] = (cyc == restartAt);
            if (doneAt == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        startS[sel] = 1'b0;
        if (doneAt == 0)
            checkOutput("done_timeout", 128'd0, 128'd1);
    endtask

    localparam logic [127:0] T1_IMG = 128'h9ABCDF00_11111110_80000000_00010000;

    int runs, doneAt;

    initial begin
        resetn  = 1'b0;
        vsew    = 3'd0;
        nbLanes = 2'd0;
        for (int i = 0; i < 3; i++) startS[i] = 1'b0;
        vs1 = {32'h89ABCDEF, 32'h12345678, 32'h7FFF8000, 32'h0000FFFF};
        vs2 = {32'h11111111, 32'hFEDCBA98, 32'h00008000, 32'h00000001};

        #3;
        checkOutput("rst_vd_out", vdOut[0], 128'd0);
        checkOutput("rst_flags", {124'd0, runS[0], busyS[0], doneS[0], errS[0]}, 128'd0);
        checkOutput("rst_index", {118'd0, idxS[0]}, 128'd0);
        @(negedge clk);
        resetn = 1'b1;

        // 32-bit elements on a 16-bit lane: two chunks each, carry across the halves.
        applyStimulus(0, 3'd2, 2'd0, 0, runs, doneAt);
        checkOutput("t1_runs", 128'(runs), 128'd8);
        checkOutput("t1_done_at", 128'(doneAt), 128'd9);
        checkOutput("t1_busy_err", {126'd0, busyS[0], errS[0]}, 128'b10);
        for (int k = 0; k < idxQ.size(); k++) begin
            checkOutput($sformatf("t1_index%0d", k), 128'(idxQ[k]), 128'(16 * k));
            checkOutput($sformatf("t1_off%0d", k), 128'(offQ[k]), 128'(k % 2));
        end
        checkOutput("t1_vd_out", vdOut[0], T1_IMG);
        @(negedge clk);
        checkOutput("t1_idle_flags", {125'd0, busyS[0], doneS[0], runS[0]}, 128'd0);
        checkOutput("t1_vd_hold", vdOut[0], T1_IMG);

        // Byte elements: sixteen single-chunk elements, offset stays zero.
        applyStimulus(0, 3'd0, 2'd0, 0, runs, doneAt);
        checkOutput("t2_runs", 128'(runs), 128'd16);
        checkOutput("t2_done_at", 128'(doneAt), 128'd17);
        for (int k = 0; k < idxQ.size(); k++) begin
            checkOutput($sformatf("t2_index%0d", k), 128'(idxQ[k]), 128'(8 * k));
            checkOutput($sformatf("t2_off%0d", k), 128'(offQ[k]), 128'd0);
        end
        checkOutput("t2_vd_out", vdOut[0], expImage(vs1, vs2, 8, 0, 1));

        // Lane 1 of two, 16-bit elements: odd elements only.
        applyStimulus(1, 3'd1, 2'd1, 0, runs, doneAt);
        checkOutput("t3_runs", 128'(runs), 128'd4);
        checkOutput("t3_done_at", 128'(doneAt), 128'd5);
        for (int k = 0; k < idxQ.size(); k++)
            checkOutput($sformatf("t3_index%0d", k), 128'(idxQ[k]), 128'(16 + 32 * k));
        checkOutput("t3_vd_out", vdOut[1], expImage(vs1, vs2, 16, 1, 2));
        checkOutput("t3_even_zero", vdOut[1] & {4{32'h0000FFFF}}, 128'd0);

        // Illegal SEW: straight to done with err, image cleared.
        applyStimulus(0, 3'd4, 2'd0, 0, runs, doneAt);
        checkOutput("t4_runs", 128'(runs), 128'd0);
        checkOutput("t4_done_at", 128'(doneAt), 128'd1);
        checkOutput("t4_err", {127'd0, errS[0]}, 128'd1);
        checkOutput("t4_vd_out", vdOut[0], 128'd0);
        @(negedge clk);
        checkOutput("t4_err_hold", {127'd0, errS[0]}, 128'd1);
        applyStimulus(0, 3'd2, 2'd0, 0, runs, doneAt);
        checkOutput("t4_err_clear", {127'd0, errS[0]}, 128'd0);
        checkOutput("t4_vd_after", vdOut[0], T1_IMG);

        // Start re-pulsed mid-run must not disturb anything.
        applyStimulus(0, 3'd2, 2'd0, 3, runs, doneAt);
        checkOutput("t5_runs", 128'(runs), 128'd8);
        checkOutput("t5_done_at", 128'(doneAt), 128'd9);
        checkOutput("t5_vd_out", vdOut[0], T1_IMG);
        @(negedge clk);
        checkOutput("t5_no_restart", {126'd0, busyS[0], runS[0]}, 128'd0);

        // Asynchronous reset in the middle of a run.
        vsew      = 3'd2;
        nbLanes   = 2'd0;
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_partial_nonzero", {127'd0, vdOut[0] != 128'd0}, 128'd1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t5_rst_flags", {124'd0, runS[0], busyS[0], doneS[0], errS[0]}, 128'd0);
        checkOutput("t5_rst_vd_out", vdOut[0], 128'd0);
        checkOutput("t5_rst_index", {114'd0, offS[0], idxS[0]}, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(0, 3'd2, 2'd0, 0, runs, doneAt);
        checkOutput("t5_after_rst_runs", 128'(runs), 128'd8);
        checkOutput("t5_after_rst_vd", vdOut[0], T1_IMG);

        // 64-bit elements on an 8-bit lane: eight chunks, carry rippling through all.
        vs1 = {64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF};
        vs2 = {64'h1111111111111111, 64'h0000000000000001};
        applyStimulus(2, 3'd3, 2'd0, 0, runs, doneAt);
        checkOutput("t6_runs", 128'(runs), 128'd16);
        checkOutput("t6_done_at", 128'(doneAt), 128'd17);
        for (int k = 0; k < idxQ.size(); k++) begin
            checkOutput($sformatf("t6_index%0d", k), 128'(idxQ[k]), 128'(8 * k));
            checkOutput($sformatf("t6_off%0d", k), 128'(offQ[k]), 128'(k % 8));
        end
        checkOutput("t6_vd_out", vdOut[2], {64'h123456789ABCDF00, 64'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
